// File: rtl/alu_pkg.sv
// Shared ALU control codes, arbiter state encoding and default width.
package alu_pkg;

  localparam int XLEN_DEFAULT = 32;

  // ALU control codes, identical to the core ALU decoder outputs
  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b0001;
  localparam logic [3:0] ALU_AND   = 4'b0010;
  localparam logic [3:0] ALU_OR    = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SLTU  = 4'b0110;
  localparam logic [3:0] ALU_AUIPC = 4'b1000;
  localparam logic [3:0] ALU_LUI   = 4'b1001;
  localparam logic [3:0] ALU_SLL   = 4'b1010;
  localparam logic [3:0] ALU_SRA   = 4'b1011;
  localparam logic [3:0] ALU_SRL   = 4'b1100;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } arb_state_e;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: operands plus control code to result/zero/illegal.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      ctrl,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  logic [4:0] shamt_s;

  assign shamt_s = b[4:0];

  // Decode the control code and compute the result; unknown codes give 0 and flag illegal
  always_comb begin
    result  = '0;
    illegal = 1'b0;
    case (ctrl)
      ALU_ADD:   result = a + b;
      ALU_AUIPC: result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  result = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_SLL:   result = a << shamt_s;
      ALU_SRL:   result = a >> shamt_s;
      ALU_SRA:   result = $unsigned($signed(a) >>> shamt_s);
      ALU_LUI:   result = b;
      default: begin
        result  = '0;
        illegal = 1'b1;
      end
    endcase
    zero = (result == '0);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two valid/ready requesters,
// with the result held on a response channel until accepted.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*XLEN-1:0] req_a,
  input  logic [2*XLEN-1:0] req_b,
  input  logic [7:0]        req_ctrl,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [XLEN-1:0]   rsp_result,
  output logic              rsp_zero,
  output logic              rsp_illegal
);

  arb_state_e      state_q, state_d;
  logic            prio_q, prio_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [3:0]      ctrl_q, ctrl_d;
  logic            id_q, id_d;

  logic            grant_s;
  logic            accept_s;

  // Pick the granted requester and raise its ready only while idle and out of reset
  always_comb begin
    grant_s   = 1'b0;
    req_ready = 2'b00;
    if (req_valid == 2'b11) begin
      grant_s = prio_q;
    end else if (req_valid[1]) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
    if (!reset && (state_q == ST_IDLE) && (req_valid != 2'b00)) begin
      req_ready[grant_s] = 1'b1;
    end else begin
      req_ready = 2'b00;
    end
    accept_s = ((req_valid & req_ready) != 2'b00);
  end

  // Next-state logic: capture the granted operation, then hold it until the response is taken
  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    a_d     = a_q;
    b_d     = b_q;
    ctrl_d  = ctrl_q;
    id_d    = id_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          a_d     = grant_s ? req_a[2*XLEN-1:XLEN] : req_a[XLEN-1:0];
          b_d     = grant_s ? req_b[2*XLEN-1:XLEN] : req_b[XLEN-1:0];
          ctrl_d  = grant_s ? req_ctrl[7:4] : req_ctrl[3:0];
          id_d    = grant_s;
          prio_d  = ~grant_s;
          state_d = ST_RESP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and captured-operand registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= 4'b0000;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ctrl_q  <= ctrl_d;
      id_q    <= id_d;
    end
  end

  alu_core #(.XLEN(XLEN)) u_alu_core (
    .a       (a_q),
    .b       (b_q),
    .ctrl    (ctrl_q),
    .result  (rsp_result),
    .zero    (rsp_zero),
    .illegal (rsp_illegal)
  );

  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Scoreboard bench for alu_share_arbiter: a transaction-level model predicts
// grants and results, a monitor compares DUT outputs against the queue.
module tb_alu_share_arbiter;

  typedef struct {
    logic        id;
    logic [31:0] res;
    logic        zero;
    logic        ill;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] a0, b0, a1, b1;
  logic [3:0]  c0, c1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero;
  logic        rsp_illegal;

  // model state
  exp_t        q[$];
  exp_t        idle_exp;
  logic        busy;
  logic        prio;
  logic [1:0]  exp_ready;

  int checks;
  int errors;

  alu_share_arbiter #(.XLEN(32)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       ({a1, a0}),
    .req_b       ({b1, b0}),
    .req_ctrl    ({c1, c0}),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_illegal (rsp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU written from the operation table
  function automatic exp_t ref_op(input logic id, input logic [3:0] c,
                                  input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int unsigned s;
    logic [31:0] ones;
    s = b[4:0];
    ones = 32'hFFFF_FFFF;
    e.id = id;
    e.ill = 1'b0;
    case (c)
      4'd0, 4'd8: e.res = a + b;
      4'd1:  e.res = a - b;
      4'd2:  e.res = a & b;
      4'd3:  e.res = a | b;
      4'd4:  e.res = a ^ b;
      4'd5:  e.res = (a[31] != b[31]) ? {31'd0, a[31]} : ((a < b) ? 32'd1 : 32'd0);
      4'd6:  e.res = (a < b) ? 32'd1 : 32'd0;
      4'd10: e.res = a << s;
      4'd12: e.res = a >> s;
      4'd11: e.res = (a >> s) | (a[31] ? ~(ones >> s) : 32'd0);
      4'd9:  e.res = b;
      default: begin
        e.res = 32'd0;
        e.ill = 1'b1;
      end
    endcase
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the clock edge to the model using the inputs the DUT just sampled
  task automatic model_edge();
    exp_t e;
    logic g;
    if (reset) begin
      busy = 1'b0;
      prio = 1'b0;
      q.delete();
      idle_exp = '{id: 1'b0, res: 32'd0, zero: 1'b1, ill: 1'b0};
    end else if (busy) begin
      if (rsp_ready) busy = 1'b0;
    end else if (req_valid != 2'b00) begin
      g = (req_valid == 2'b11) ? prio : req_valid[1];
      e = g ? ref_op(1'b1, c1, a1, b1) : ref_op(1'b0, c0, a0, b0);
      q.push_back(e);
      idle_exp = e;
      busy = 1'b1;
      prio = ~g;
    end
  endtask

  // One cycle: advance model on the edge, then drive the next inputs
  task automatic step(input logic rst, input logic [1:0] v,
                      input logic [31:0] na0, input logic [31:0] nb0, input logic [3:0] nc0,
                      input logic [31:0] na1, input logic [31:0] nb1, input logic [3:0] nc1,
                      input logic rdy);
    @(posedge clk);
    model_edge();
    #1;
    reset = rst; req_valid = v; rsp_ready = rdy;
    a0 = na0; b0 = nb0; c0 = nc0;
    a1 = na1; b1 = nb1; c1 = nc1;
    if (rst || busy || v == 2'b00) exp_ready = 2'b00;
    else if (v == 2'b11) exp_ready = prio ? 2'b10 : 2'b01;
    else exp_ready = v;
  endtask

  // Monitor: compare DUT outputs against the scoreboard away from the active edge
  always @(negedge clk) begin
    exp_t e;
    chk("req_ready", {30'd0, req_ready}, {30'd0, exp_ready});
    if (!reset) begin
      chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, busy});
      if (busy) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: response expected but queue empty at %0t", $time);
        end else begin
          e = q[0];
          chk("rsp_id", {31'd0, rsp_id}, {31'd0, e.id});
          chk("rsp_result", rsp_result, e.res);
          chk("rsp_zero", {31'd0, rsp_zero}, {31'd0, e.zero});
          chk("rsp_illegal", {31'd0, rsp_illegal}, {31'd0, e.ill});
          if (rsp_ready) void'(q.pop_front());
        end
      end else begin
        chk("idle_id", {31'd0, rsp_id}, {31'd0, idle_exp.id});
        chk("idle_result", rsp_result, idle_exp.res);
        chk("idle_zero", {31'd0, rsp_zero}, {31'd0, idle_exp.zero});
        chk("idle_illegal", {31'd0, rsp_illegal}, {31'd0, idle_exp.ill});
      end
    end
  end

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 40);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    checks = 0; errors = 0;
    busy = 1'b0; prio = 1'b0; exp_ready = 2'b00;
    idle_exp = '{id: 1'b0, res: 32'd0, zero: 1'b1, ill: 1'b0};
    reset = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
    a0 = 32'd7; b0 = 32'd9; c0 = 4'd0; a1 = 32'd1; b1 = 32'd2; c1 = 4'd1;

    // reset with both requesters valid: req_ready must stay 00
    repeat (3) step(1'b1, 2'b11, 32'd7, 32'd9, 4'd0, 32'd1, 32'd2, 4'd1, 1'b1);
    step(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
    step(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);

    // single request on port 0: 5 - 3
    step(1'b0, 2'b01, 32'd5, 32'd3, 4'b0001, 32'd0, 32'd0, 4'd0, 1'b1);
    step(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
    step(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);

    // contention from reset: alternating grants, port 1 slt/sltu
    step(1'b1, 2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 2'b11, rnd_operand(), rnd_operand(), 4'b0000,
           32'hFFFF_FFFF, 32'd1, (i % 4 < 2) ? 4'b0101 : 4'b0110, 1'b1);
    end

    // backpressure: hold the response 5 cycles with both requesters waiting
    step(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
    step(1'b0, 2'b01, 32'd100, 32'd23, 4'b0100, 32'd0, 32'd0, 4'd0, 1'b0);
    repeat (5) step(1'b0, 2'b11, 32'd1, 32'd1, 4'd0, 32'd2, 32'd2, 4'd0, 1'b0);
    step(1'b0, 2'b11, 32'd1, 32'd1, 4'd0, 32'd2, 32'd2, 4'd0, 1'b1);
    step(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
    step(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);

    // shifts, LUI and an illegal code, each held for two cycles
    repeat (2) step(1'b0, 2'b01, 32'h8000_0000, 32'h21, 4'b1011, 32'd0, 32'd0, 4'd0, 1'b1);
    repeat (2) step(1'b0, 2'b01, 32'h8000_0000, 32'h21, 4'b1100, 32'd0, 32'd0, 4'd0, 1'b1);
    repeat (2) step(1'b0, 2'b10, 32'd0, 32'd0, 4'd0, 32'hDEAD_BEEF, 32'h1234_5000, 4'b1001, 1'b1);
    repeat (2) step(1'b0, 2'b01, 32'd42, 32'd17, 4'b0111, 32'd0, 32'd0, 4'd0, 1'b1);
    repeat (2) step(1'b0, 2'b01, 32'h0000_1000, 32'h0000_0004, 4'b1000, 32'd0, 32'd0, 4'd0, 1'b1);
    step(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);

    // reset while port 1 result is pending, then both valid -> port 0
    step(1'b0, 2'b10, 32'd0, 32'd0, 4'd0, 32'd9, 32'd4, 4'b0001, 1'b0);
    step(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    step(1'b1, 2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b0);
    step(1'b0, 2'b11, 32'd11, 32'd22, 4'b0000, 32'd33, 32'd44, 4'b0000, 1'b1);
    step(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
    step(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);

    // randomized traffic with random backpressure and occasional reset
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) == 0), 2'($urandom_range(0, 3)),
           rnd_operand(), rnd_operand(), 4'($urandom_range(0, 15)),
           rnd_operand(), rnd_operand(), 4'($urandom_range(0, 15)),
           ($urandom_range(0, 3) != 0));
    end
    step(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
    step(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 32'd0, 32'd0, 4'd0, 1'b1);
    @(negedge clk);
    #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
# alu_share_arbiter

Shares one 32-bit ALU between two requesters, e.g. the core datapath (port 0) and a debug/CSR helper (port 1). Each requester presents operands plus a 4-bit ALU control code over a valid/ready handshake. A round-robin arbiter grants one operation at a time. The result is registered and held on a response channel until the consumer accepts it. The ALU control codes are the same ones the ALU decoder drives in the core, so decoded controls pass through unchanged.

## Interface
Parameters:
- XLEN, 32, operand/result width (shift amount always from b[4:0]).

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept; at most one bit high.
- req_a  in  2*XLEN  operand A per requester; requester i uses bits [i*XLEN +: XLEN].
- req_b  in  2*XLEN  operand B per requester, same packing.
- req_ctrl  in  8  ALU control per requester, [i*4 +: 4].
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester that issued the held result.
- rsp_result  out  XLEN  ALU result.
- rsp_zero  out  1  rsp_result == 0.
- rsp_illegal  out  1  issued control code was unsupported.

## Operation
- Control codes:
  - 0000 add
  - 0001 sub
  - 0010 and
  - 0011 or
  - 0100 xor
  - 0101 slt (signed, result 1/0)
  - 0110 sltu
  - 1010 sll
  - 1011 sra
  - 1100 srl
  - 1000 a+b (AUIPC; the caller supplies PC as A)
  - 1001 pass b (LUI)
  - Any other code: result 0, rsp_illegal=1.
- Arithmetic is modulo 2^XLEN; overflow is ignored.
- FSM has two states:
  - IDLE: rsp_valid=0.
    - Grant = the requester with valid set. If both are valid, grant goes to the one selected by priority pointer `prio`.
    - req_ready[grant]=1 combinationally, only in IDLE.
    - On handshake: capture a, b, ctrl and id into registers; toggle `prio` to the non-granted requester; go to RESP.
  - RESP: rsp_valid=1. The result is computed combinationally from the captured registers and stays stable.
    - req_ready=0.
    - On rsp_valid & rsp_ready, go to IDLE.
- Only one operation is outstanding; there is no accept in the same cycle as a response handshake.
- When only one requester is valid, it is granted regardless of `prio`; `prio` still toggles away from it.
- Requester inputs may change while not granted; only handshake-cycle values are used.

## Timing
- Reset values:
  - state=IDLE, prio=0, rsp_valid=0, req_ready=00 during reset.
  - rsp_id=0, rsp_result=0, rsp_zero=1, rsp_illegal=0 (captured registers cleared to a=0, b=0, ctrl=0000).
- Latency:
  - Handshake in cycle N → rsp_valid high in cycle N+1 with the final result.
  - Earliest next accept is cycle N+2, when rsp_ready=1 in N+1.
  - Peak throughput is one operation per 2 cycles.
- Backpressure: rsp_ready low holds all rsp_* outputs constant indefinitely.
- Reset asserted mid-operation (RESP): the pending result is discarded; the next cycle shows reset values; `prio` returns to 0.
- req_ready must not depend on rsp_ready (no combinational path response→request).

## Structure
- Package alu_pkg:
  - 4-bit ALU control localparams (ALU_ADD … ALU_LUI).
  - State encoding for IDLE/RESP.
  - XLEN default.
- The ALU decoder uses the same alu_pkg constants.
- One sub-module, alu_core: purely combinational a, b, ctrl → result, zero, illegal. The arbiter instantiates it on the captured registers.

## Test plan
- Single request: port 0, a=5, b=3, ctrl=0001, rsp_ready=1.
  - req_ready=01 in the handshake cycle.
  - Next cycle: rsp_valid=1, rsp_id=0, result=2, zero=0.
- Contention: both valid every cycle from reset, rsp_ready=1 → grants alternate 0,1,0,1.
  - Port 1 ops: a=0xFFFFFFFF, b=1, ctrl=0101 → result 1.
  - Port 1 ops: same operands, ctrl=0110 → result 0.
- Backpressure: rsp_ready=0 for 5 cycles after result.
  - rsp_* stable, req_ready=00 throughout.
  - Release → IDLE; the next grant is the next cycle.
- Shifts/LUI:
  - a=0x80000000, b=0x21, ctrl=1011 → 0xC0000000.
  - ctrl=1100 → 0x40000000.
  - ctrl=1001, b=0x12345000 → 0x12345000.
- Illegal: ctrl=0111 → result 0, zero=1, illegal=1; handshake completes normally.
- Reset in RESP, port 1 pending: next cycle rsp_valid=0, prio=0. A simultaneous request on both ports after reset is granted to port 0.
